// File: rtl/alu_operand_stage.sv
// Issue stage ahead of the 8-bit mipsALU: register file, ALUOp/funct decode,
// operand-b select and an ID/EX pipeline register with a valid/ready handshake.
//
// Ports:
//   clk, reset             - rising-edge clock, synchronous active-high reset
//   in_valid / in_ready    - upstream issue handshake (in_ready is combinational)
//   rs, rt, rd             - source registers for a/b, destination tag
//   alu_op, funct          - MIPS ALUOp and funct field
//   imm, use_imm           - immediate operand and b-select
//   flush                  - kill the held instruction (and any same-cycle issue)
//   wb_en, wb_addr, wb_data- register-file write-back port
//   out_valid / out_ready  - downstream handshake
//   a_out, b_out, alu_ctl_out, rd_out, illegal_out - registered ID/EX payload
module alu_operand_stage #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] imm,
    input  logic              use_imm,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [3:0]        alu_ctl_out,
    output logic [ADDR_W-1:0] rd_out,
    output logic              illegal_out
);

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;

    logic [DATA_W-1:0] rf_q [NREGS];

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] a_q, b_q;
    logic [3:0]        ctl_q;
    logic [ADDR_W-1:0] rd_q;
    logic              ill_q;

    logic              wb_hit;
    logic              accept;
    logic [DATA_W-1:0] a_rd, rt_rd, b_sel;
    logic [3:0]        ctl_dec;
    logic              ill_dec;

    // Register file: R0 is never written, so it stays zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_hit) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    assign wb_hit = wb_en && (wb_addr != '0);

    // Operand read with write-first bypass; R0 reads as zero.
    always_comb begin
        a_rd  = '0;
        rt_rd = '0;
        if (rs != '0) begin
            a_rd = (wb_hit && (wb_addr == rs)) ? wb_data : rf_q[rs];
        end
        if (rt != '0) begin
            rt_rd = (wb_hit && (wb_addr == rt)) ? wb_data : rf_q[rt];
        end
        b_sel = use_imm ? imm : rt_rd;
    end

    // ALUOp/funct decode; unsupported combinations yield AND code with illegal set.
    always_comb begin
        ctl_dec = CTL_AND;
        ill_dec = 1'b0;
        unique case (alu_op)
            2'b00: ctl_dec = CTL_ADD;
            2'b01: ctl_dec = CTL_SUB;
            2'b10: begin
                unique case (funct)
                    6'b100000: ctl_dec = CTL_ADD;
                    6'b100010: ctl_dec = CTL_SUB;
                    6'b100100: ctl_dec = CTL_AND;
                    6'b100101: ctl_dec = CTL_OR;
                    6'b101010: ctl_dec = CTL_SLT;
                    6'b100111: ctl_dec = CTL_NOR;
                    default:   ill_dec = 1'b1;
                endcase
            end
            default: ill_dec = 1'b1;
        endcase
    end

    // Handshake: flush kills both the held op and any same-cycle issue.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // ID/EX register: payload only loads on accept, so it holds through stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ctl_q   <= '0;
            rd_q    <= '0;
            ill_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                a_q   <= a_rd;
                b_q   <= b_sel;
                ctl_q <= ctl_dec;
                rd_q  <= rd;
                ill_q <= ill_dec;
            end
        end
    end

    assign out_valid   = valid_q;
    assign a_out       = a_q;
    assign b_out       = b_q;
    assign alu_ctl_out = ctl_q;
    assign rd_out      = rd_q;
    assign illegal_out = ill_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: a driver issues directed and random
// traffic while an abstract model predicts each accepted op; a separate monitor
// compares the presented payload against the queue head every cycle it is valid.
module tb_alu_operand_stage;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned NREGS  = 8;
    localparam int unsigned ADDR_W = 3;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [3:0]        ctl;
        logic [ADDR_W-1:0] rd;
        logic              ill;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] rs, rt, rd;
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
    logic              flush;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] a_out, b_out;
    logic [3:0]        alu_ctl_out;
    logic [ADDR_W-1:0] rd_out;
    logic              illegal_out;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    // Reference state
    logic [DATA_W-1:0] mrf [NREGS];
    logic              m_valid = 1'b0;

    logic [5:0] fn_tab  [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    logic [3:0] ctl_tab [6] = '{4'b0010,   4'b0110,   4'b0000,   4'b0001,   4'b0111,   4'b1100};

    always #5 clk = ~clk;

    alu_operand_stage #(.DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .rs(rs), .rt(rt), .rd(rd), .alu_op(alu_op), .funct(funct), .imm(imm),
        .use_imm(use_imm), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
        .a_out(a_out), .b_out(b_out), .alu_ctl_out(alu_ctl_out), .rd_out(rd_out),
        .illegal_out(illegal_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Table-driven decode reference.
    task automatic ref_decode(input logic [1:0] op, input logic [5:0] f,
                              output logic [3:0] ctl, output logic ill);
        ctl = 4'b0000;
        ill = 1'b1;
        if (op == 2'd0) begin
            ctl = 4'b0010; ill = 1'b0;
        end else if (op == 2'd1) begin
            ctl = 4'b0110; ill = 1'b0;
        end else if (op == 2'd2) begin
            for (int i = 0; i < 6; i++) begin
                if (fn_tab[i] == f) begin
                    ctl = ctl_tab[i]; ill = 1'b0;
                end
            end
        end
    endtask

    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        if (a == 0) return '0;
        if (wb_en && wb_addr != 0 && wb_addr == a) return wb_data;
        return mrf[a];
    endfunction

    // One clock of traffic with the currently driven inputs.
    task automatic step();
        logic mir;
        logic acc;
        exp_t e;
        #1;
        mir = !m_valid || out_ready;
        check("in_ready", 32'(in_ready), 32'(mir));
        acc = in_valid && mir && !flush && !reset;
        if (acc) begin
            e.a  = ref_read(rs);
            e.b  = use_imm ? imm : ref_read(rt);
            e.rd = rd;
            ref_decode(alu_op, funct, e.ctl, e.ill);
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (reset) begin
            m_valid = 1'b0;
            for (int i = 0; i < int'(NREGS); i++) mrf[i] = '0;
            sb_q.delete();
        end else begin
            if (wb_en && wb_addr != 0) mrf[wb_addr] = wb_data;
            if (flush)          m_valid = 1'b0;
            else if (acc)       m_valid = 1'b1;
            else if (out_ready) m_valid = 1'b0;
        end
        check("out_valid", 32'(out_valid), 32'(m_valid));
    endtask

    task automatic idle();
        reset = 0; in_valid = 0; rs = 0; rt = 0; rd = 0; alu_op = 0; funct = 0;
        imm = 0; use_imm = 0; flush = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
        out_ready = 1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        idle(); wb_en = 1; wb_addr = a; wb_data = d; step();
    endtask

    task automatic issue(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] t,
                         input logic [1:0] op, input logic [5:0] f);
        idle(); in_valid = 1; rs = s; rt = t; rd = s ^ t; alu_op = op; funct = f;
        step();
    endtask

    // Monitor: compare the held payload each valid cycle; retire on transfer or flush.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                check("a_out",       32'(a_out),       32'(sb_q[0].a));
                check("b_out",       32'(b_out),       32'(sb_q[0].b));
                check("alu_ctl_out", 32'(alu_ctl_out), 32'(sb_q[0].ctl));
                check("rd_out",      32'(rd_out),      32'(sb_q[0].rd));
                check("illegal_out", 32'(illegal_out), 32'(sb_q[0].ill));
                if (out_ready || flush) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < int'(NREGS); i++) mrf[i] = '0;
        idle();
        reset = 1; step(); step();
        idle();
        check("rst_a_out",   32'(a_out), 32'd0);
        check("rst_b_out",   32'(b_out), 32'd0);
        check("rst_ctl",     32'(alu_ctl_out), 32'd0);
        check("rst_rd",      32'(rd_out), 32'd0);
        check("rst_illegal", 32'(illegal_out), 32'd0);
        step();
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Registers read zero after reset
        for (int i = 1; i < int'(NREGS); i++) issue(3'(i), 3'(i), 2'b00, 6'd0);

        // Write R1/R2 then AND
        wr(3'd1, 8'h01);
        wr(3'd2, 8'h03);
        issue(3'd1, 3'd2, 2'b10, 6'b100100);

        // Same-cycle bypass with immediate b
        idle(); wb_en = 1; wb_addr = 3; wb_data = 8'h5A;
        in_valid = 1; rs = 3; use_imm = 1; imm = 8'h07; alu_op = 2'b00; step();

        // Decode sweep and illegal cases, back-to-back
        for (int i = 0; i < 6; i++) issue(3'd1, 3'd2, 2'b10, fn_tab[i]);
        issue(3'd1, 3'd2, 2'b10, 6'b000000);
        issue(3'd1, 3'd2, 2'b11, 6'b100000);
        issue(3'd1, 3'd2, 2'b01, 6'b111111);
        idle(); step();

        // Stall for 3 cycles with a write to the held rs and a rejected issue
        idle(); in_valid = 1; rs = 1; rt = 2; out_ready = 0; step();
        for (int i = 0; i < 3; i++) begin
            idle(); out_ready = 0; in_valid = 1; rs = 2;
            wb_en = 1; wb_addr = 1; wb_data = 8'h77; step();
        end
        idle(); step(); step();

        // Flush a same-cycle issue, then flush a stalled op
        idle(); in_valid = 1; rs = 1; flush = 1; step();
        idle(); in_valid = 1; rs = 2; out_ready = 0; step();
        idle(); out_ready = 0; flush = 1; wb_en = 1; wb_addr = 4; wb_data = 8'h44; step();
        issue(3'd4, 3'd4, 2'b00, 6'd0);

        // R0 writes are ignored
        wr(3'd0, 8'hFF);
        issue(3'd0, 3'd0, 2'b00, 6'd0);

        // Reset in the middle of a stall
        idle(); in_valid = 1; rs = 1; out_ready = 0; step();
        idle(); out_ready = 0; reset = 1; step();
        idle(); step();
        check("midrst_a_out", 32'(a_out), 32'd0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 299) == 0);
            in_valid = 1'($urandom_range(0, 1));
            rs       = 3'($urandom);
            rt       = 3'($urandom);
            rd       = 3'($urandom);
            alu_op   = 2'($urandom);
            funct    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 5)];
            imm      = 8'($urandom);
            use_imm  = 1'($urandom_range(0, 1));
            flush    = ($urandom_range(0, 9) == 0);
            wb_en    = 1'($urandom_range(0, 1));
            wb_addr  = 3'($urandom);
            wb_data  = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Drain and confirm nothing is left outstanding
        idle(); step(); step(); step();
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
